// File: rtl/occupancy_controller.sv
// rtl/occupancy_controller.sv - car-park beam decoder FSM with saturating occupancy counter
module occupancy_controller #(
  parameter int COUNT_W   = 4,
  parameter int MAX_COUNT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a,
  input  logic               b,
  output logic               inc,
  output logic               dec,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty,
  output logic               seq_err,
  output logic               sat_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EN1  = 3'd1,
    EN2  = 3'd2,
    EN3  = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6,
    WAIT = 3'd7
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = COUNT_W'(MAX_COUNT);

  state_t             state_q, state_d;
  logic               inc_q, inc_d;
  logic               dec_q, dec_d;
  logic               seq_err_q, seq_err_d;
  logic               sat_err_q, sat_err_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic [1:0] ab;
  logic [1:0] held_ab;

  assign ab = {a, b};

  // Sensor pattern each tracking state was entered on; WAIT has none and is handled on its own.
  always_comb begin
    held_ab = 2'b00;
    case (state_q)
      EN1, EX3: held_ab = 2'b10;
      EN2, EX2: held_ab = 2'b11;
      EN3, EX1: held_ab = 2'b01;
      default:  held_ab = 2'b00;
    endcase
  end

  // Next state and pulse decode; a double-bit jump overrides the per-state table.
  always_comb begin
    state_d   = state_q;
    inc_d     = 1'b0;
    dec_d     = 1'b0;
    seq_err_d = 1'b0;
    if (state_q == WAIT) begin
      if (ab == 2'b00) state_d = IDLE;
    end else if (ab == held_ab) begin
      state_d = state_q;
    end else if ((ab ^ held_ab) == 2'b11) begin
      seq_err_d = 1'b1;
      state_d   = (ab == 2'b00) ? IDLE : WAIT;
    end else begin
      case (state_q)
        IDLE: state_d = (ab == 2'b10) ? EN1 : EX1;
        EN1:  state_d = (ab == 2'b11) ? EN2 : IDLE;
        EN2:  state_d = (ab == 2'b01) ? EN3 : EN1;
        EN3: begin
          if (ab == 2'b00) begin
            state_d = IDLE;
            inc_d   = 1'b1;
          end else begin
            state_d = EN2;
          end
        end
        EX1:  state_d = (ab == 2'b11) ? EX2 : IDLE;
        EX2:  state_d = (ab == 2'b10) ? EX3 : EX1;
        EX3: begin
          if (ab == 2'b00) begin
            state_d = IDLE;
            dec_d   = 1'b1;
          end else begin
            state_d = EX2;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Saturating counter update, applied on the same edge that registers inc/dec.
  always_comb begin
    count_d   = count_q;
    sat_err_d = 1'b0;
    if (inc_d) begin
      if (count_q == CNT_MAX) sat_err_d = 1'b1;
      else                    count_d   = count_q + 1'b1;
    end else if (dec_d) begin
      if (count_q == '0) sat_err_d = 1'b1;
      else               count_d   = count_q - 1'b1;
    end
  end

  // State, pulse and counter registers; reset drops any partial sequence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      seq_err_q <= 1'b0;
      sat_err_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      inc_q     <= inc_d;
      dec_q     <= dec_d;
      seq_err_q <= seq_err_d;
      sat_err_q <= sat_err_d;
      count_q   <= count_d;
    end
  end

  assign inc     = inc_q;
  assign dec     = dec_q;
  assign seq_err = seq_err_q;
  assign sat_err = sat_err_q;
  assign count   = count_q;
  assign full    = (count_q == CNT_MAX);
  assign empty   = (count_q == '0);

endmodule

// File: tb/tb_occupancy_controller.sv
// tb/tb_occupancy_controller.sv - scoreboard bench for occupancy_controller
`timescale 1ns/1ps
module tb_occupancy_controller;

  logic       clk;
  logic       reset;
  logic       a, b;
  logic       inc, dec, full, empty, seq_err, sat_err;
  logic [3:0] count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic       inc;
    logic       dec;
    logic       seq;
    logic       sat;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  occupancy_controller #(.COUNT_W(4), .MAX_COUNT(15)) dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .inc     (inc),
    .dec     (dec),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .seq_err (seq_err),
    .sat_err (sat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one {a,b} sample; any pulse expected on the sampling edge goes to the scoreboard.
  task automatic step(input logic na, input logic nb, input logic e_inc, input logic e_dec,
                      input logic e_seq, input logic e_sat, input logic [3:0] e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    a = na;
    b = nb;
    if (e_inc || e_dec || e_seq || e_sat) begin
      e.cyc = cyc + 1;
      e.inc = e_inc;
      e.dec = e_dec;
      e.seq = e_seq;
      e.sat = e_sat;
      e.cnt = e_cnt;
      exp_q.push_back(e);
    end
  endtask

  task automatic quiet(input logic na, input logic nb);
    step(na, nb, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic chk_status(input string name, input logic [3:0] e_cnt, input logic e_full,
                            input logic e_empty);
    @(posedge clk);
    #2;
    checks++;
    if (count !== e_cnt || full !== e_full || empty !== e_empty) begin
      failures++;
      $display("FAIL %s: count=%0d full=%b empty=%b, required count=%0d full=%b empty=%b",
               name, count, full, empty, e_cnt, e_full, e_empty);
    end
  endtask

  task automatic entry(input logic e_sat, input logic [3:0] e_cnt);
    quiet(0, 0); quiet(1, 0); quiet(1, 1); quiet(0, 1);
    step(0, 0, 1'b1, 1'b0, 1'b0, e_sat, e_cnt);
  endtask

  task automatic exit_seq(input logic e_sat, input logic [3:0] e_cnt);
    quiet(0, 0); quiet(0, 1); quiet(1, 1); quiet(1, 0);
    step(0, 0, 1'b0, 1'b1, 1'b0, e_sat, e_cnt);
  endtask

  // Monitor: pops the scoreboard when a pulse is presented or an expected one is due.
  always @(negedge clk) begin
    if (!reset) begin
      if (inc || dec || seq_err || sat_err) begin
        checks++;
        failures++;
        $display("FAIL reset_pulses: inc=%b dec=%b seq_err=%b sat_err=%b, required all 0",
                 inc, dec, seq_err, sat_err);
      end
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_pulse: expected at cycle %0d, no pulse observed", exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        checks++;
        if ({inc, dec, seq_err, sat_err, count} !==
            {exp_q[0].inc, exp_q[0].dec, exp_q[0].seq, exp_q[0].sat, exp_q[0].cnt}) begin
          failures++;
          $display("FAIL pulse_cycle_%0d: inc=%b dec=%b seq=%b sat=%b count=%0d, required inc=%b dec=%b seq=%b sat=%b count=%0d",
                   cyc, inc, dec, seq_err, sat_err, count, exp_q[0].inc, exp_q[0].dec,
                   exp_q[0].seq, exp_q[0].sat, exp_q[0].cnt);
        end
        void'(exp_q.pop_front());
      end else if (inc || dec || seq_err || sat_err) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse_cycle_%0d: inc=%b dec=%b seq=%b sat=%b, required none",
                 cyc, inc, dec, seq_err, sat_err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    a = 1'b0;
    b = 1'b0;
    // Reset held with the sensors toggling.
    quiet(1, 0); quiet(1, 1); quiet(0, 1); quiet(0, 0); quiet(1, 1);
    chk_status("reset_hold", 4'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    a = 1'b0;
    b = 1'b0;
    quiet(0, 0);
    chk_status("after_release", 4'd0, 1'b0, 1'b1);

    entry(1'b0, 4'd1);
    chk_status("entry", 4'd1, 1'b0, 1'b0);

    exit_seq(1'b0, 4'd0);
    chk_status("exit", 4'd0, 1'b0, 1'b1);

    // Entry backed out and aborted.
    quiet(0, 0); quiet(1, 0); quiet(1, 1); quiet(1, 0); quiet(0, 0);
    chk_status("backout", 4'd0, 1'b0, 1'b1);

    exit_seq(1'b1, 4'd0);
    chk_status("exit_at_empty", 4'd0, 1'b0, 1'b1);

    for (int i = 1; i <= 15; i++) entry(1'b0, 4'(i));
    chk_status("fill_to_15", 4'd15, 1'b1, 1'b0);

    entry(1'b1, 4'd15);
    chk_status("entry_at_full", 4'd15, 1'b1, 1'b0);

    // 00->11 jumps to WAIT; the following 01,00 must not complete an exit.
    quiet(0, 0);
    step(1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15);
    quiet(0, 1); quiet(0, 0);
    chk_status("illegal_from_idle", 4'd15, 1'b1, 1'b0);

    // EN2 with 11->00 returns to IDLE with seq_err; the next 10 restarts an entry normally.
    quiet(1, 0); quiet(1, 1);
    step(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15);
    exit_seq(1'b0, 4'd14);
    chk_status("illegal_en2_then_exit", 4'd14, 1'b0, 1'b0);

    // Reset mid-entry; 01,00 afterwards is an aborted exit.
    quiet(1, 0); quiet(1, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    a = 1'b0;
    b = 1'b1;
    quiet(0, 0);
    chk_status("reset_mid_sequence", 4'd0, 1'b0, 1'b1);

    quiet(0, 0); quiet(0, 0);
    @(negedge clk);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL leftover_expectation: cycle %0d never checked", exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/occupancy_controller.md
Name: occupancy_controller

Overview:
- Sequences the car-park occupancy datapath.
- Decodes the two beam sensors a/b into completed entry and exit events, and drives one-cycle inc/dec pulses.
- Owns the saturating occupancy counter and its full/empty/error status.
- Sits between the sensor stimulus and the scoreboard: inc/dec/count are the signals the scoreboard checks.

Parameters:
- COUNT_W, 4, width of count; must satisfy MAX_COUNT <= 2**COUNT_W-1.
- MAX_COUNT, 15, capacity; count saturates here.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- a  input  1  outer beam sensor, 1 = blocked; synchronous to clk.
- b  input  1  inner beam sensor, 1 = blocked; synchronous to clk.
- inc  output  1  one-cycle pulse: entry completed.
- dec  output  1  one-cycle pulse: exit completed.
- count  output  COUNT_W  current occupancy.
- full  output  1  count == MAX_COUNT.
- empty  output  1  count == 0.
- seq_err  output  1  one-cycle pulse: illegal sensor transition (both bits changed in one cycle).
- sat_err  output  1  one-cycle pulse: entry at full, or exit at empty.

Behaviour:
- Reset values: state IDLE, count 0, inc/dec/seq_err/sat_err 0, so empty=1 and full=0. Reset takes effect immediately, mid-sequence included, and discards any partial sequence.
- inc, dec, seq_err, sat_err and count are registered. full and empty decode the count register only.
- FSM states, written as {a,b}:
  - IDLE: 10 -> EN1; 01 -> EX1; 11 -> WAIT with seq_err; 00 stays.
  - EN1 (10): 11 -> EN2; 00 -> IDLE (abort, no pulse); 01 -> WAIT with seq_err.
  - EN2 (11): 01 -> EN3; 10 -> EN1 (back-out); 00 -> IDLE with seq_err.
  - EN3 (01): 00 -> IDLE with inc; 11 -> EN2; 10 -> WAIT with seq_err.
  - EX1 (01): 11 -> EX2; 00 -> IDLE (abort); 10 -> WAIT with seq_err.
  - EX2 (11): 10 -> EX3; 01 -> EX1; 00 -> IDLE with seq_err.
  - EX3 (10): 00 -> IDLE with dec; 11 -> EX2; 01 -> WAIT with seq_err.
  - WAIT: stays until {a,b}=00, then -> IDLE. No pulses are issued from WAIT.
  - Unchanged {a,b} holds every state.
  - General seq_err rule: both bits change in one cycle. The next state is IDLE if the new value is 00, otherwise WAIT.
- Latency: on the first rising edge where a completing 00 is sampled, inc/dec is asserted and count is updated in the same edge. Each pulse lasts exactly one cycle.
- Counter:
  - inc with count < MAX_COUNT: count+1.
  - inc with count == MAX_COUNT: count holds, sat_err pulses with inc.
  - dec with count > 0: count-1.
  - dec with count == 0: count holds, sat_err pulses with dec.
  - The counter never wraps.
- Mutual exclusion: inc and dec are never asserted together; the FSM cannot issue both in one cycle. seq_err never coincides with inc or dec.
- No synchronisers: a and b arrive synchronous to clk.

Test Plan:
- Reset: hold reset=0 with a/b toggling -> count=0, empty=1, no pulses. Release, drive 00 -> outputs unchanged.
- Entry: 00,10,11,01,00, one cycle each, from count=0 -> inc=1 for exactly one cycle on the edge sampling the final 00, count=1, empty=0, dec=0.
- Exit plus back-out:
  - Exit 00,01,11,10,00 from count=1 -> dec pulse, count=0, empty=1.
  - Then 00,10,11,10,00 (entry aborted) -> no inc, count=0.
- Saturation: 15 entries -> count=15, full=1. A 16th entry -> inc and sat_err pulse together, count stays 15. An exit at count=0 -> dec and sat_err, count stays 0.
- Illegal jump:
  - 00->11 -> seq_err one cycle, state WAIT. Then 01,00 -> no dec, count unchanged.
  - EN2 with 11->00 -> seq_err, returns to IDLE, no inc.
- Reset mid-sequence: 10,11 then reset=0 for one cycle, release with 01,00 -> FSM goes IDLE->EX1->IDLE (abort), no inc, no dec, count=0.
